sseg_scan_n: RTL

- Parametrised N-digit multiplexed seven-segment driver; next generation of the team's 4-digit sseg block.
- Adds an internal refresh prescaler, per-digit decimal point and blank controls, leading-zero suppression, 16-level PWM brightness, and frame-coherent input snapshotting.
- Sits between display-value logic (counters, BCD converters) and board anode/cathode pins.

---
 rtl/sseg_scan_n.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/sseg_scan_n.sv
// sseg_scan_n: N-digit multiplexed seven-segment scanner.
//   - An internal prescaler sets the slot length to 2^PRESC_W clk cycles per digit.
//   - Inputs are captured into shadow registers once per frame, so a frame never
//     mixes old and new values.
//   - Each digit has its own decimal point and blank controls.
//   - Optional leading-zero suppression and 16-level PWM brightness.
//   - Anodes stay dark for the first two cycles of each slot (ghosting guard).
//   - Cathodes and the decimal point are active-low.
//   - Anode polarity is set by AN_ACTIVE_LOW.
//   - All outputs are registered: one clk of latency from idx/prescaler.
// Optional feature macro: SSEG_BLINK_EN adds a per-digit blink input and a 6-bit
// frame counter. A blinking digit is dark while frame counter bit 5 is set.
module sseg_scan_n #(
  parameter int DIGITS        = 8,
  parameter int PRESC_W       = 17,
  parameter bit AN_ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enabled,
  input  logic [4*DIGITS-1:0] digits,
  input  logic [DIGITS-1:0]   dp,
  input  logic [DIGITS-1:0]   blank,
`ifdef SSEG_BLINK_EN
  input  logic [DIGITS-1:0]   blink,
`endif
  input  logic                lz_en,
  input  logic [3:0]          brightness,
  output logic [DIGITS-1:0]   sseg_an,
  output logic [6:0]          sseg_ca,
  output logic                sseg_dp
);

  localparam int                 IDX_W    = $clog2(DIGITS);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0]  AN_IDLE  = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic [6:0]         CA_OFF   = 7'h7F;

  // Active-low segment pattern for one hex nibble (a = bit 0 .. g = bit 6).
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // Scan position state
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                first_q, first_d;   // snapshot still pending since reset

  // Frame shadow copy of the display inputs
  logic [4*DIGITS-1:0] sh_digits_q, sh_digits_d;
  logic [DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic [DIGITS-1:0]   sh_blank_q, sh_blank_d;
  logic                sh_lz_q, sh_lz_d;
`ifdef SSEG_BLINK_EN
  logic [DIGITS-1:0]   sh_blink_q, sh_blink_d;
  logic [5:0]          frame_q, frame_d;
`endif

  // Registered outputs
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          ca_q, ca_d;
  logic                dp_q, dp_d;

  // Decode helpers
  logic                tick;
  logic                wrap;
  logic                snap;
  logic [4*DIGITS-1:0] src_digits;
  logic [DIGITS-1:0]   src_dp;
  logic [DIGITS-1:0]   src_blank;
  logic                src_lz;
  logic [DIGITS-1:0]   blank_eff;
  logic [DIGITS-1:0]   supp;
  logic                pwm_on;
  logic                guard;
  logic                shown;
  logic                dp_shown;
  logic [DIGITS-1:0]   onehot;

  // Prescaler, digit index and frame snapshot next-state
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    tick        = enabled && (presc_q == {PRESC_W{1'b1}});
    wrap        = tick && (idx_q == LAST_IDX);
    snap        = (enabled && first_q) || wrap;

    presc_d     = enabled ? presc_q + 1'b1 : presc_q;
    idx_d       = idx_q;
    if (tick) begin
      idx_d = wrap ? '0 : idx_q + 1'b1;
    end
    first_d     = first_q && !enabled;

    sh_digits_d = sh_digits_q;
    sh_dp_d     = sh_dp_q;
    sh_blank_d  = sh_blank_q;
    sh_lz_d     = sh_lz_q;
`ifdef SSEG_BLINK_EN
    sh_blink_d  = sh_blink_q;
    frame_d     = wrap ? frame_q + 6'd1 : frame_q;
`endif
    if (snap) begin
      sh_digits_d = digits;
      sh_dp_d     = dp;
      sh_blank_d  = blank;
      sh_lz_d     = lz_en;
`ifdef SSEG_BLINK_EN
      sh_blink_d  = blink;
`endif
    end
  end

  // Display source: the shadow copy, except on the very first enabled cycle
  // after reset where the values being captured are shown straight away.
  always_comb begin
    src_digits = first_q ? digits : sh_digits_q;
    src_dp     = first_q ? dp     : sh_dp_q;
    src_blank  = first_q ? blank  : sh_blank_q;
    src_lz     = first_q ? lz_en  : sh_lz_q;
`ifdef SSEG_BLINK_EN
    blank_eff  = src_blank | ((first_q ? blink : sh_blink_q) & {DIGITS{frame_q[5]}});
`else
    blank_eff  = src_blank;
`endif
  end

  // Leading-zero suppression, scanning from the most significant digit down
  always_comb begin
    logic upper_clear;   // every digit above the current one is zero or blanked
    supp        = '0;
    upper_clear = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (src_lz && (src_digits[4*i +: 4] == 4'h0) && upper_clear) begin
        supp[i] = 1'b1;
      end
      upper_clear = upper_clear && ((src_digits[4*i +: 4] == 4'h0) || blank_eff[i]);
    end
  end

  // Output decode for the current slot position
  always_comb begin
    pwm_on   = presc_q[PRESC_W-1 -: 4] <= brightness;
    guard    = presc_q[PRESC_W-1:1] == '0;
    shown    = !blank_eff[idx_q] && !supp[idx_q];
    dp_shown = src_dp[idx_q] && !blank_eff[idx_q];
    onehot   = ((shown || dp_shown) && pwm_on && !guard) ? (DIGITS'(1) << idx_q) : '0;

    an_d     = AN_IDLE;
    ca_d     = CA_OFF;
    dp_d     = 1'b1;
    if (enabled) begin
      an_d = AN_ACTIVE_LOW ? ~onehot : onehot;
      ca_d = shown ? hex_to_seg(src_digits[{idx_q, 2'b00} +: 4]) : CA_OFF;
      dp_d = !dp_shown;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values of the others.
    if (!rst_n) begin
      presc_q     <= '0;
      idx_q       <= '0;
      first_q     <= 1'b1;
      // NOTE: the shadow copy is reset too, so nothing undefined reaches the
      // pins before the first snapshot.
      sh_digits_q <= '0;
      sh_dp_q     <= '0;
      sh_blank_q  <= '0;
      sh_lz_q     <= 1'b0;
`ifdef SSEG_BLINK_EN
      sh_blink_q  <= '0;
      frame_q     <= '0;
`endif
      an_q        <= AN_IDLE;
      ca_q        <= CA_OFF;
      dp_q        <= 1'b1;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      first_q     <= first_d;
      sh_digits_q <= sh_digits_d;
      sh_dp_q     <= sh_dp_d;
      sh_blank_q  <= sh_blank_d;
      sh_lz_q     <= sh_lz_d;
`ifdef SSEG_BLINK_EN
      sh_blink_q  <= sh_blink_d;
      frame_q     <= frame_d;
`endif
      an_q        <= an_d;
      ca_q        <= ca_d;
      dp_q        <= dp_d;
    end
  end

  assign sseg_an = an_q;
  assign sseg_ca = ca_q;
  assign sseg_dp = dp_q;

endmodule
